// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: memory control bundle,
// arbiter state encoding and access-size encodings.
package mem_port_arbiter_pkg;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] size;
    logic       sign;
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check for one memory request: ctrl sanity,
// size encoding, natural alignment and address range.
module mem_req_check
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  output logic        legal
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic aligned;
  logic in_range;

  always_comb begin
    aligned = 1'b0;
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~addr[0];
      SZ_WORD: aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign in_range = ({1'b0, addr} < ADDR_LIMIT);
  assign legal    = (mem_read ^ mem_write) && aligned && in_range;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single data-memory port: fixed priority to port 0
// with a starvation override for port 1, one-cycle access, registered response.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS  = 2048,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p0_valid,
  output logic        o_p0_ready,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  mem_ctrl_t   i_p0_ctrl,
  output logic        o_p0_rvalid,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_rerr,
  input  logic        i_p1_valid,
  output logic        o_p1_ready,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  mem_ctrl_t   i_p1_ctrl,
  output logic        o_p1_rvalid,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_rerr,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_writeData,
  output mem_ctrl_t   o_ctrlMEM,
  input  logic [31:0] i_readData
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e  state;
  logic        owner;
  logic [3:0]  starve_cnt;
  logic        legal0, legal1;
  logic        arb_phase, force1, accept, acc_legal;
  mem_ctrl_t   acc_ctrl;
  logic [31:0] acc_addr, acc_wdata;

  mem_req_check #(.DEPTH_WORDS(DEPTH_WORDS)) u_chk0 (
    .addr(i_p0_addr), .mem_read(i_p0_ctrl.memRead), .mem_write(i_p0_ctrl.memWrite),
    .size(i_p0_ctrl.size), .legal(legal0)
  );

  mem_req_check #(.DEPTH_WORDS(DEPTH_WORDS)) u_chk1 (
    .addr(i_p1_addr), .mem_read(i_p1_ctrl.memRead), .mem_write(i_p1_ctrl.memWrite),
    .size(i_p1_ctrl.size), .legal(legal1)
  );

  // Ready depends only on state, counter and the valids, never on the other ready.
  assign arb_phase  = ((state == IDLE) || (state == RESP)) && !i_reset;
  assign force1     = (starve_cnt == LIMIT) && i_p0_valid && i_p1_valid;
  assign o_p0_ready = arb_phase && i_p0_valid && !force1;
  assign o_p1_ready = arb_phase && i_p1_valid && (!i_p0_valid || force1);
  assign accept     = o_p0_ready || o_p1_ready;

  assign acc_ctrl  = o_p1_ready ? i_p1_ctrl  : i_p0_ctrl;
  assign acc_addr  = o_p1_ready ? i_p1_addr  : i_p0_addr;
  assign acc_wdata = o_p1_ready ? i_p1_wdata : i_p0_wdata;
  assign acc_legal = o_p1_ready ? legal1     : legal0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      starve_cnt  <= 4'd0;
      o_ctrlMEM   <= '0;
      o_memAddr   <= 32'd0;
      o_writeData <= 32'd0;
      o_p0_rvalid <= 1'b0;
      o_p0_rerr   <= 1'b0;
      o_p0_rdata  <= 32'd0;
      o_p1_rvalid <= 1'b0;
      o_p1_rerr   <= 1'b0;
      o_p1_rdata  <= 32'd0;
    end else begin
      o_ctrlMEM   <= '0;
      o_p0_rvalid <= 1'b0;
      o_p0_rerr   <= 1'b0;
      o_p0_rdata  <= 32'd0;
      o_p1_rvalid <= 1'b0;
      o_p1_rerr   <= 1'b0;
      o_p1_rdata  <= 32'd0;

      if (!i_p1_valid || o_p1_ready) begin
        starve_cnt <= 4'd0;
      end else if (o_p0_ready && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            owner <= o_p1_ready;
            if (acc_legal) begin
              state       <= ACCESS;
              o_ctrlMEM   <= acc_ctrl;
              o_memAddr   <= acc_addr;
              o_writeData <= acc_wdata;
            end else begin
              state <= ERR;
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (owner) begin
            o_p1_rvalid <= 1'b1;
            o_p1_rdata  <= o_ctrlMEM.memRead ? i_readData : 32'd0;
          end else begin
            o_p0_rvalid <= 1'b1;
            o_p0_rdata  <= o_ctrlMEM.memRead ? i_readData : 32'd0;
          end
        end
        ERR: begin
          state <= RESP;
          if (owner) begin
            o_p1_rvalid <= 1'b1;
            o_p1_rerr   <= 1'b1;
          end else begin
            o_p0_rvalid <= 1'b1;
            o_p0_rerr   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-addressed memory
// attached to the shared port.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam mem_ctrl_t LW  = '{memRead: 1'b1, memWrite: 1'b0, size: SZ_WORD, sign: 1'b1};
  localparam mem_ctrl_t SW  = '{memRead: 1'b0, memWrite: 1'b1, size: SZ_WORD, sign: 1'b0};
  localparam mem_ctrl_t SB  = '{memRead: 1'b0, memWrite: 1'b1, size: SZ_BYTE, sign: 1'b0};
  localparam mem_ctrl_t LB  = '{memRead: 1'b1, memWrite: 1'b0, size: SZ_BYTE, sign: 1'b1};
  localparam mem_ctrl_t LBU = '{memRead: 1'b1, memWrite: 1'b0, size: SZ_BYTE, sign: 1'b0};
  localparam mem_ctrl_t LH  = '{memRead: 1'b1, memWrite: 1'b0, size: SZ_HALF, sign: 1'b1};
  localparam mem_ctrl_t RW  = '{memRead: 1'b1, memWrite: 1'b1, size: SZ_WORD, sign: 1'b0};
  localparam mem_ctrl_t S11 = '{memRead: 1'b1, memWrite: 1'b0, size: 2'b11,   sign: 1'b0};

  logic        i_clk, i_reset;
  logic        i_p0_valid, o_p0_ready, o_p0_rvalid, o_p0_rerr;
  logic [31:0] i_p0_addr, i_p0_wdata, o_p0_rdata;
  mem_ctrl_t   i_p0_ctrl;
  logic        i_p1_valid, o_p1_ready, o_p1_rvalid, o_p1_rerr;
  logic [31:0] i_p1_addr, i_p1_wdata, o_p1_rdata;
  mem_ctrl_t   i_p1_ctrl;
  logic [31:0] o_memAddr, o_writeData, i_readData;
  mem_ctrl_t   o_ctrlMEM;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DEPTH_WORDS(2048), .STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_p0_valid(i_p0_valid), .o_p0_ready(o_p0_ready), .i_p0_addr(i_p0_addr),
    .i_p0_wdata(i_p0_wdata), .i_p0_ctrl(i_p0_ctrl), .o_p0_rvalid(o_p0_rvalid),
    .o_p0_rdata(o_p0_rdata), .o_p0_rerr(o_p0_rerr),
    .i_p1_valid(i_p1_valid), .o_p1_ready(o_p1_ready), .i_p1_addr(i_p1_addr),
    .i_p1_wdata(i_p1_wdata), .i_p1_ctrl(i_p1_ctrl), .o_p1_rvalid(o_p1_rvalid),
    .o_p1_rdata(o_p1_rdata), .o_p1_rerr(o_p1_rerr),
    .o_memAddr(o_memAddr), .o_writeData(o_writeData), .o_ctrlMEM(o_ctrlMEM),
    .i_readData(i_readData)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // Memory on the shared port: little-endian, extended read data.
  logic [31:0] mem [0:2047];
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  int          bsel, hsel;

  always @(posedge i_clk) begin
    if (o_ctrlMEM.memWrite) begin
      case (o_ctrlMEM.size)
        SZ_BYTE: mem[o_memAddr[12:2]][8*int'(o_memAddr[1:0]) +: 8] <= o_writeData[7:0];
        SZ_HALF: mem[o_memAddr[12:2]][16*int'(o_memAddr[1]) +: 16] <= o_writeData[15:0];
        default: mem[o_memAddr[12:2]] <= o_writeData;
      endcase
    end
  end

  always_comb begin
    rd_word = mem[o_memAddr[12:2]];
    bsel    = 8 * int'(o_memAddr[1:0]);
    hsel    = 16 * int'(o_memAddr[1]);
    rd_byte = rd_word[bsel +: 8];
    rd_half = rd_word[hsel +: 16];
    case (o_ctrlMEM.size)
      SZ_BYTE: i_readData = o_ctrlMEM.sign ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      SZ_HALF: i_readData = o_ctrlMEM.sign ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      default: i_readData = rd_word;
    endcase
  end

  // Presents a request, waits (bounded) for ready, returns 1ns after the accept edge.
  task automatic send(input bit p, input mem_ctrl_t c, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    if (p) begin
      i_p1_valid = 1'b1; i_p1_ctrl = c; i_p1_addr = a; i_p1_wdata = d;
    end else begin
      i_p0_valid = 1'b1; i_p0_ctrl = c; i_p0_addr = a; i_p0_wdata = d;
    end
    #1;
    while (!(p ? o_p1_ready : o_p0_ready) && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_timeout: port %0d ready never seen, required within 20 cycles", p);
    end
    @(posedge i_clk);
    #1;
    if (p) i_p1_valid = 1'b0;
    else   i_p0_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_p0_valid = 1'b1; i_p1_valid = 1'b1;
    i_p0_ctrl = LW; i_p1_ctrl = LW; i_p0_addr = 0; i_p1_addr = 0;
    i_p0_wdata = 0; i_p1_wdata = 0;
    idle_cycles(2);
    checks++;
    if (o_p0_ready !== 1'b0 || o_p1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b required 00", o_p0_ready, o_p1_ready);
    end
    i_p0_valid = 1'b0; i_p1_valid = 1'b0;
    checks++;
    if (o_ctrlMEM !== '0 || o_memAddr !== 32'd0 || o_writeData !== 32'd0) begin
      errors++;
      $display("FAIL reset_mem: ctrl=%h addr=%h wdata=%h required all 0", o_ctrlMEM, o_memAddr, o_writeData);
    end
    checks++;
    if (o_p0_rvalid !== 1'b0 || o_p1_rvalid !== 1'b0 || o_p0_rerr !== 1'b0 || o_p1_rerr !== 1'b0 ||
        o_p0_rdata !== 32'd0 || o_p1_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_resp: rvalid=%b%b rerr=%b%b required 0", o_p0_rvalid, o_p1_rvalid, o_p0_rerr, o_p1_rerr);
    end
    i_reset = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_word();
    send(0, SW, 32'h10, 32'hDEADBEEF);
    checks++;
    if (o_ctrlMEM !== SW || o_memAddr !== 32'h10 || o_writeData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_access: ctrl=%h addr=%h wdata=%h required %h 10 deadbeef", o_ctrlMEM, o_memAddr, o_writeData, SW);
    end
    idle_cycles(1);
    checks++;
    if (o_p0_rvalid !== 1'b1 || o_p0_rerr !== 1'b0 || o_p0_rdata !== 32'd0 || o_p1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL sw_ack: rvalid=%b rerr=%b rdata=%h p1_rvalid=%b required 1 0 0 0", o_p0_rvalid, o_p0_rerr, o_p0_rdata, o_p1_rvalid);
    end
    send(0, LW, 32'h10, 32'h0);
    idle_cycles(1);
    checks++;
    if (o_p0_rvalid !== 1'b1 || o_p0_rerr !== 1'b0 || o_p0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_data: rvalid=%b rerr=%b rdata=%h required 1 0 deadbeef", o_p0_rvalid, o_p0_rerr, o_p0_rdata);
    end
    idle_cycles(1);
    checks++;
    if (o_p0_rvalid !== 1'b0 || o_ctrlMEM !== '0) begin
      errors++;
      $display("FAIL lw_single_pulse: rvalid=%b ctrl=%h required 0 0", o_p0_rvalid, o_ctrlMEM);
    end
  endtask

  task automatic test_byte_half();
    mem_ctrl_t   ctl [3] = '{LB, LBU, LH};
    logic [31:0] adr [3] = '{32'h21, 32'h21, 32'h20};
    logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000};
    send(0, SB, 32'h21, 32'h12345680);
    checks++;
    if (o_ctrlMEM !== SB || o_memAddr !== 32'h21) begin
      errors++;
      $display("FAIL sb_ctrl: ctrl=%h addr=%h required %h 21", o_ctrlMEM, o_memAddr, SB);
    end
    idle_cycles(1);
    for (int i = 0; i < 3; i++) begin
      send(0, ctl[i], adr[i], 32'h0);
      checks++;
      if (o_ctrlMEM !== ctl[i]) begin
        errors++;
        $display("FAIL load_ctrl[%0d]: ctrl=%h required %h", i, o_ctrlMEM, ctl[i]);
      end
      idle_cycles(1);
      checks++;
      if (o_p0_rvalid !== 1'b1 || o_p0_rdata !== exp[i]) begin
        errors++;
        $display("FAIL load_data[%0d]: rvalid=%b rdata=%h required 1 %h", i, o_p0_rvalid, o_p0_rdata, exp[i]);
      end
    end
    idle_cycles(1);
  endtask

  task automatic test_errors();
    mem_ctrl_t   ctl [5] = '{LW, LH, SW, RW, S11};
    logic [31:0] adr [5] = '{32'h2, 32'h3, 32'h2000, 32'h40, 32'h0};
    for (int i = 0; i < 5; i++) begin
      send(0, ctl[i], adr[i], 32'h1234);
      checks++;
      if (o_ctrlMEM.memRead !== 1'b0 || o_ctrlMEM.memWrite !== 1'b0) begin
        errors++;
        $display("FAIL err_no_access[%0d]: memRead=%b memWrite=%b required 0 0", i, o_ctrlMEM.memRead, o_ctrlMEM.memWrite);
      end
      idle_cycles(1);
      checks++;
      if (o_p0_rvalid !== 1'b1 || o_p0_rerr !== 1'b1 || o_p0_rdata !== 32'd0 || o_ctrlMEM !== '0) begin
        errors++;
        $display("FAIL err_resp[%0d]: rvalid=%b rerr=%b rdata=%h required 1 1 0", i, o_p0_rvalid, o_p0_rerr, o_p0_rdata);
      end
    end
    send(0, SW, 32'h1FFC, 32'hCAFE0001);
    checks++;
    if (o_ctrlMEM !== SW) begin
      errors++;
      $display("FAIL top_word_access: ctrl=%h required %h", o_ctrlMEM, SW);
    end
    idle_cycles(1);
    checks++;
    if (o_p0_rvalid !== 1'b1 || o_p0_rerr !== 1'b0) begin
      errors++;
      $display("FAIL top_word_ack: rvalid=%b rerr=%b required 1 0", o_p0_rvalid, o_p0_rerr);
    end
    idle_cycles(1);
  endtask

  task automatic test_starvation();
    int got [11];
    int exp [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int ng = 0;
    i_p0_valid = 1'b1; i_p0_ctrl = LW; i_p0_addr = 32'h100;
    i_p1_valid = 1'b1; i_p1_ctrl = LW; i_p1_addr = 32'h200;
    for (int cyc = 0; cyc < 60 && ng < 11; cyc++) begin
      @(negedge i_clk);
      checks++;
      if (o_p0_ready && o_p1_ready) begin
        errors++;
        $display("FAIL two_ready: both readies high at cycle %0d, required at most one", cyc);
      end
      if (o_p0_ready) begin got[ng] = 0; ng++; end
      else if (o_p1_ready) begin got[ng] = 1; ng++; end
    end
    @(negedge i_clk);
    i_p0_valid = 1'b0; i_p1_valid = 1'b0;
    checks++;
    if (ng != 11) begin
      errors++;
      $display("FAIL starve_grant_count: got %0d grants required 11", ng);
    end
    for (int i = 0; i < ng; i++) begin
      checks++;
      if (got[i] != exp[i]) begin
        errors++;
        $display("FAIL starve_order[%0d]: granted port %0d required port %0d", i, got[i], exp[i]);
      end
    end
    idle_cycles(4);
  endtask

  task automatic test_back_to_back();
    send(0, LW, 32'h10, 32'h0);
    i_p1_valid = 1'b1; i_p1_ctrl = LW; i_p1_addr = 32'h20; i_p1_wdata = 32'h0;
    #1;
    checks++;
    if (o_p1_ready !== 1'b0 || o_p0_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_access: ready=%b%b required 00", o_p0_ready, o_p1_ready);
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_p0_rvalid !== 1'b1 || o_p0_rdata !== 32'hDEADBEEF || o_p1_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overlap: p0_rvalid=%b p0_rdata=%h p1_ready=%b required 1 deadbeef 1", o_p0_rvalid, o_p0_rdata, o_p1_ready);
    end
    @(posedge i_clk);
    #1;
    i_p1_valid = 1'b0;
    checks++;
    if (o_ctrlMEM !== LW || o_memAddr !== 32'h20) begin
      errors++;
      $display("FAIL b2b_p1_access: ctrl=%h addr=%h required %h 20", o_ctrlMEM, o_memAddr, LW);
    end
    idle_cycles(1);
    checks++;
    if (o_p1_rvalid !== 1'b1 || o_p1_rdata !== 32'h00008000 || o_p0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_p1_resp: p1_rvalid=%b p1_rdata=%h p0_rvalid=%b required 1 00008000 0", o_p1_rvalid, o_p1_rdata, o_p0_rvalid);
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    bit seen;
    send(0, SW, 32'h30, 32'h00000055);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    send(0, LW, 32'h10, 32'h0);
    checks++;
    if (o_ctrlMEM !== LW) begin
      errors++;
      $display("FAIL mid_lw_access: ctrl=%h required %h", o_ctrlMEM, LW);
    end
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_ctrlMEM !== '0 || o_p0_rvalid !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset_state: ctrl=%h rvalid=%b state=%0d required 0 0 0", o_ctrlMEM, o_p0_rvalid, dut.state);
    end
    i_reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      if (o_p0_rvalid || o_p1_rvalid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_no_rvalid: rvalid seen after reset, required none");
    end
    send(0, LW, 32'h30, 32'h0);
    idle_cycles(1);
    checks++;
    if (o_p0_rvalid !== 1'b1 || o_p0_rdata !== 32'h00000055) begin
      errors++;
      $display("FAIL mid_write_kept: rvalid=%b rdata=%h required 1 00000055", o_p0_rvalid, o_p0_rdata);
    end
    idle_cycles(1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    i_reset = 1'b1;
    i_p0_valid = 1'b0; i_p1_valid = 1'b0;
    i_p0_addr = 0; i_p1_addr = 0; i_p0_wdata = 0; i_p1_wdata = 0;
    i_p0_ctrl = '0; i_p1_ctrl = '0;
    @(posedge i_clk);
    #1;
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
